cmos_capture_rgb565: RTL and testbench
======================================

// Module: cmos_capture_rgb565
// PURPOSE
//  Receives the 8-bit DVP stream (vsync/href/data) from the CMOS sensor or the CMOS video simulator.
//  Pairs the bytes into 16-bit RGB565 pixels with a one-cycle pixel strobe and X/Y coordinates.
//  Drops the first frames after reset while the sensor settles, and never emits a partial frame.
//  Sits directly after the camera interface; feeds the image-processing pipeline and the frame buffer writer.
// PARAMETERS
//  VSYNC_VALID         1'b1     vsync level during active frame (1: high = frame, 0: low = frame)
//  IMG_HDISP           11'd640  pixels per line (line = 2*IMG_HDISP bytes)
//  IMG_VDISP           11'd480  lines per frame
//  CMOS_FRAME_WAITCNT  4'd10    complete frames discarded after reset before output starts
// PORTS
//  clk               in   1   CMOS pixel clock (cmos_pclk); all logic on rising edge
//  rst_n             in   1   asynchronous active-low reset
//  cmos_vsync        in   1   frame sync, polarity per VSYNC_VALID
//  cmos_href         in   1   line valid, high = data byte valid
//  cmos_data         in   8   byte stream, high byte of each pixel first
//  cmos_frame_vsync  out  1   normalised frame-active (high), gated by capture enable, pipeline-aligned
//  cmos_frame_href   out  1   href, gated by capture enable, pipeline-aligned
//  cmos_frame_clken  out  1   one-cycle strobe per completed pixel
//  cmos_frame_data   out  16  RGB565 pixel, valid when clken=1
//  cmos_frame_x      out  11  column of current pixel (0..IMG_HDISP-1)
//  cmos_frame_y      out  11  line of current pixel (0..IMG_VDISP-1)
//  frame_done        out  1   one-cycle pulse at end of every output frame
//  frame_cnt         out  8   count of completed output frames, wraps 255->0
//  line_err          out  1   one-cycle pulse: output line byte count != 2*IMG_HDISP
//  frame_err         out  1   one-cycle pulse with frame_done: line count != IMG_VDISP
// BEHAVIOUR
//  Reset (async, rst_n=0): every output and internal register = 0; capture disabled.
//  Stage 1: register vsync/href/data. vs = VSYNC_VALID ? vsync_d : ~vsync_d. Edges are detected on vs.
//  Wait counter: counts vs falling edges (frame ends), saturates at CMOS_FRAME_WAITCNT.
//   capture_en is set on a vs rising edge when the count == WAITCNT; it stays set until reset.
//   WAITCNT=0 -> output starts at the first vs rising edge after reset. A frame in progress at reset release is never output.
//  Byte pairing (capture_en & vs & href_d): byte_flag toggles each byte.
//   1st byte -> data[15:8] latched; 2nd byte -> data[7:0], clken=1 for one cycle.
//   byte_flag cleared whenever href_d=0. An odd trailing byte is discarded.
//  Latency: clken/data/x/y valid 2 clk after the edge that samples the low byte; frame_vsync/href delayed 2 clk to match.
//  X: 0 at line start, +1 after each clken; cleared on href_d falling edge.
//  Y: cleared on vs rising edge; +1 on each href_d falling edge that ended a line with >=1 pixel.
//  Counters: X and Y saturate at 2047 (no wrap); error flags report oversize lines and frames.
//  line_err: on href_d falling edge inside an output frame, if line byte count != 2*IMG_HDISP.
//  frame_done and frame_err: on vs falling edge with capture_en; frame_cnt increments in the same cycle.
//  href outside vs, or while capture_en=0: ignored; no clken, no counter change.
//  vs dropping mid-line: line is closed (Y, line_err evaluated), then the frame ends in the same cycle.
// TESTING
//  1 Hold rst_n=0, toggle all inputs -> all outputs stay 0. Release mid-frame with WAITCNT=0 -> no clken until the next vs rising edge.
//  2 WAITCNT=2, IMG_HDISP=4, IMG_VDISP=2, drive 4 frames -> frames 1-2 give 0 clken; frames 3-4 give 8 clken each; frame_done x2; frame_cnt=2.
//  3 Line bytes 12,34,56,78 -> data 16'h1234 at x=0,y=0, then 16'h5678 at x=1; clken 2 clk after byte 34.
//  4 Line of 7 bytes (HDISP=4) -> 3 clken, last byte dropped, line_err pulse, Y still increments.
//  5 Frame with 3 lines (VDISP=2) -> frame_err pulse coincident with frame_done.
//  6 VSYNC_VALID=0 with inverted vsync, stimulus of test 2 -> identical output sequence.
//  7 Drive the CMOS simulator (HDISP=8 bytes, VDISP=4) into this block -> 4 px/line, data {n,n+1}, no line_err with IMG_HDISP=4.

Source files
------------

// File: rtl/cmos_capture_rgb565.sv
// DVP byte-stream capture: pairs sensor bytes into RGB565 pixels with X/Y coordinates,
// discarding the first frames after reset and never emitting a partial frame.
module cmos_capture_rgb565 #(
  parameter logic        VSYNC_VALID        = 1'b1,
  parameter logic [10:0] IMG_HDISP          = 11'd640,
  parameter logic [10:0] IMG_VDISP          = 11'd480,
  parameter logic [3:0]  CMOS_FRAME_WAITCNT = 4'd10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  output logic        cmos_frame_vsync,
  output logic        cmos_frame_href,
  output logic        cmos_frame_clken,
  output logic [15:0] cmos_frame_data,
  output logic [10:0] cmos_frame_x,
  output logic [10:0] cmos_frame_y,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic        line_err,
  output logic        frame_err
);

  localparam logic [11:0] LINE_BYTES = {IMG_HDISP, 1'b0};
  localparam logic [11:0] FRAME_LINES = {1'b0, IMG_VDISP};

  // input register stage
  logic        vsync_d;
  logic        href_d;
  logic [7:0]  data_d;
  logic        s1_valid;
  logic        vs_q;
  logic        vs_q_valid;

  // capture state
  logic [3:0]  wait_cnt;
  logic        capture_en;
  logic        byte_flag;
  logic [7:0]  hi_byte;
  logic        line_open;
  logic [11:0] byte_cnt;
  logic [10:0] x_cnt;
  logic [11:0] line_cnt;

  // pixel / event stage
  logic        s2_clken;
  logic [15:0] s2_data;
  logic [10:0] s2_x;
  logic [10:0] s2_y;
  logic        s2_line_err;
  logic        s2_frame_done;
  logic        s2_frame_err;
  logic        s2_vs;
  logic        s2_href;

  logic        vs;
  logic        vs_rise;
  logic        vs_fall;
  logic        cap_set;
  logic        en_now;
  logic        active;
  logic        line_end;
  logic        line_has_px;
  logic [11:0] line_cnt_next;
  logic [10:0] x_cnt_inc;
  logic [11:0] byte_cnt_inc;
  logic [10:0] y_sat;

  always_comb begin
    vs            = VSYNC_VALID ? vsync_d : ~vsync_d;
    // edges are only trusted once vs_q holds a sampled (not reset) value
    vs_rise       = vs_q_valid & vs & ~vs_q;
    vs_fall       = vs_q_valid & ~vs & vs_q;
    cap_set       = vs_rise & ~capture_en & (wait_cnt == CMOS_FRAME_WAITCNT);
    en_now        = capture_en | cap_set;
    active        = en_now & vs & href_d;
    // a line closes when href drops or vs drops underneath it
    line_end      = line_open & ~active;
    line_has_px   = (byte_cnt >= 12'd2);
    line_cnt_next = line_cnt;
    if (line_end && line_has_px && (line_cnt != 12'hFFF))
      line_cnt_next = line_cnt + 12'd1;
    x_cnt_inc     = (x_cnt == 11'h7FF) ? x_cnt : x_cnt + 11'd1;
    byte_cnt_inc  = (byte_cnt == 12'hFFF) ? byte_cnt : byte_cnt + 12'd1;
    y_sat         = (line_cnt > 12'd2047) ? 11'h7FF : line_cnt[10:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d    <= 1'b0;
      href_d     <= 1'b0;
      data_d     <= 8'd0;
      s1_valid   <= 1'b0;
      vs_q       <= 1'b0;
      vs_q_valid <= 1'b0;
      wait_cnt   <= 4'd0;
      capture_en <= 1'b0;
    end else begin
      vsync_d    <= cmos_vsync;
      href_d     <= cmos_href;
      data_d     <= cmos_data;
      s1_valid   <= 1'b1;
      vs_q       <= vs;
      vs_q_valid <= s1_valid;
      if (vs_fall && (wait_cnt != CMOS_FRAME_WAITCNT))
        wait_cnt <= wait_cnt + 4'd1;
      if (cap_set)
        capture_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_flag <= 1'b0;
      hi_byte   <= 8'd0;
      line_open <= 1'b0;
      byte_cnt  <= 12'd0;
      x_cnt     <= 11'd0;
      line_cnt  <= 12'd0;
      s2_clken  <= 1'b0;
      s2_data   <= 16'd0;
      s2_x      <= 11'd0;
      s2_y      <= 11'd0;
    end else begin
      s2_clken <= 1'b0;
      if (active) begin
        byte_flag <= ~byte_flag;
        line_open <= 1'b1;
        byte_cnt  <= byte_cnt_inc;
        if (!byte_flag) begin
          hi_byte <= data_d;
        end else begin
          s2_clken <= 1'b1;
          s2_data  <= {hi_byte, data_d};
          s2_x     <= x_cnt;
          s2_y     <= y_sat;
          x_cnt    <= x_cnt_inc;
        end
      end else begin
        byte_flag <= 1'b0;
        if (line_end) begin
          line_open <= 1'b0;
          byte_cnt  <= 12'd0;
          x_cnt     <= 11'd0;
        end
      end
      if (vs_rise)
        line_cnt <= 12'd0;
      else
        line_cnt <= line_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_line_err   <= 1'b0;
      s2_frame_done <= 1'b0;
      s2_frame_err  <= 1'b0;
      s2_vs         <= 1'b0;
      s2_href       <= 1'b0;
    end else begin
      s2_line_err   <= line_end & (byte_cnt != LINE_BYTES);
      // frame close sees the line count including a line cut off by vs
      s2_frame_done <= vs_fall & capture_en;
      s2_frame_err  <= vs_fall & capture_en & (line_cnt_next != FRAME_LINES);
      s2_vs         <= vs & en_now;
      s2_href       <= href_d & en_now;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmos_frame_vsync <= 1'b0;
      cmos_frame_href  <= 1'b0;
      cmos_frame_clken <= 1'b0;
      cmos_frame_data  <= 16'd0;
      cmos_frame_x     <= 11'd0;
      cmos_frame_y     <= 11'd0;
      frame_done       <= 1'b0;
      frame_cnt        <= 8'd0;
      line_err         <= 1'b0;
      frame_err        <= 1'b0;
    end else begin
      cmos_frame_vsync <= s2_vs;
      cmos_frame_href  <= s2_href;
      cmos_frame_clken <= s2_clken;
      cmos_frame_data  <= s2_data;
      cmos_frame_x     <= s2_x;
      cmos_frame_y     <= s2_y;
      frame_done       <= s2_frame_done;
      line_err         <= s2_line_err;
      frame_err        <= s2_frame_err;
      if (s2_frame_done)
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_cmos_capture_rgb565.sv
// Randomized DVP stimulus into three capture instances (normal, inverted vsync, no frame wait),
// checked against a frame-level reference model through per-instance event queues.
module tb_cmos_capture_rgb565;

  localparam int N = 3;
  localparam int HD = 4;
  localparam int VD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vs_act = 1'b0;
  logic href = 1'b0;
  logic [7:0] data = 8'd0;

  always #5 clk = ~clk;

  logic        o_vs[N];
  logic        o_href[N];
  logic        o_clken[N];
  logic [15:0] o_data[N];
  logic [10:0] o_x[N];
  logic [10:0] o_y[N];
  logic        o_fd[N];
  logic [7:0]  o_cnt[N];
  logic        o_le[N];
  logic        o_fe[N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      localparam logic       VV = (gi == 1) ? 1'b0 : 1'b1;
      localparam logic [3:0] WC = (gi == 2) ? 4'd0 : 4'd2;
      logic vsync_pin;
      assign vsync_pin = VV ? vs_act : ~vs_act;
      cmos_capture_rgb565 #(
        .VSYNC_VALID(VV), .IMG_HDISP(11'd4), .IMG_VDISP(11'd2), .CMOS_FRAME_WAITCNT(WC)
      ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmos_vsync(vsync_pin), .cmos_href(href), .cmos_data(data),
        .cmos_frame_vsync(o_vs[gi]), .cmos_frame_href(o_href[gi]),
        .cmos_frame_clken(o_clken[gi]), .cmos_frame_data(o_data[gi]),
        .cmos_frame_x(o_x[gi]), .cmos_frame_y(o_y[gi]),
        .frame_done(o_fd[gi]), .frame_cnt(o_cnt[gi]),
        .line_err(o_le[gi]), .frame_err(o_fe[gi])
      );
    end
  endgenerate

  typedef struct {
    int          kind;   // 0 pixel, 1 line error, 2 frame done
    logic [15:0] d;
    int          x;
    int          y;
    logic        ferr;
    logic [7:0]  cnt;
    bit          lat;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  ev_t q2[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int lat_expect = -1;

  int falls = 0;
  int fcnt[N];
  int line_len[$];
  logic [7:0] fbytes[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_ev(input int i, input ev_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_ev(input int i, output ev_t e, output bit ok);
    ok = 1'b0;
    e = '{default: 0};
    case (i)
      0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Reference: a frame is output by an instance once enough frame ends have been seen.
  task automatic model_frame(input bit mark_lat);
    for (int i = 0; i < N; i++) begin
      int w;
      int pos;
      int y;
      ev_t e;
      w = (i == 2) ? 0 : 2;
      if (falls >= w) begin
        pos = 0;
        y = 0;
        for (int l = 0; l < line_len.size(); l++) begin
          for (int p = 0; p < line_len[l] / 2; p++) begin
            e = '{default: 0};
            e.kind = 0;
            e.d = {fbytes[pos + 2*p], fbytes[pos + 2*p + 1]};
            e.x = p;
            e.y = (y > 2047) ? 2047 : y;
            e.lat = (i == 0) && mark_lat && (l == 0) && (p == 0);
            push_ev(i, e);
          end
          if (line_len[l] != 2*HD) begin
            e = '{default: 0};
            e.kind = 1;
            push_ev(i, e);
          end
          if (line_len[l] >= 2) y++;
          pos += line_len[l];
        end
        fcnt[i] = (fcnt[i] + 1) % 256;
        e = '{default: 0};
        e.kind = 2;
        e.ferr = (y != VD);
        e.cnt = fcnt[i][7:0];
        push_ev(i, e);
      end
    end
    falls++;
  endtask

  task automatic drive(input logic v, input logic h, input logic [7:0] d);
    vs_act = v;
    href = h;
    data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add_line(input int nb, input int mode, input int base);
    logic [7:0] fixed_pat[8];
    fixed_pat = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9a, 8'hbc, 8'hde, 8'hf0};
    line_len.push_back(nb);
    for (int b = 0; b < nb; b++) begin
      case (mode)
        1: fbytes.push_back(fixed_pat[b % 8]);
        2: fbytes.push_back(8'(base + b));
        default: fbytes.push_back(8'($urandom_range(0, 255)));
      endcase
    end
  endtask

  task automatic send_frame(input bit mid_drop, input bit mark_lat);
    int pos;
    repeat ($urandom_range(2, 4)) drive(1'b0, 1'b0, 8'($urandom));
    if ($urandom_range(0, 1) == 1) begin
      repeat (3) drive(1'b0, 1'b1, 8'($urandom));
      repeat (2) drive(1'b0, 1'b0, 8'($urandom));
    end
    repeat (2) drive(1'b1, 1'b0, 8'($urandom));
    pos = 0;
    for (int l = 0; l < line_len.size(); l++) begin
      for (int b = 0; b < line_len[l]; b++) begin
        if (mark_lat && l == 0 && b == 1) lat_expect = cyc + 3;
        drive(1'b1, 1'b1, fbytes[pos + b]);
      end
      pos += line_len[l];
      if (mid_drop && l == line_len.size() - 1)
        drive(1'b0, 1'b1, 8'($urandom));
      else
        repeat ($urandom_range(2, 4)) drive(1'b1, 1'b0, 8'($urandom));
    end
    drive(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic run_frame(input bit mid_drop, input bit mark_lat);
    model_frame(mark_lat);
    send_frame(mid_drop, mark_lat);
    line_len.delete();
    fbytes.delete();
  endtask

  always @(negedge clk) begin
    ev_t e;
    bit ok;
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        n_checks++;
        if ({o_vs[i], o_href[i], o_clken[i], o_data[i], o_x[i], o_y[i],
             o_fd[i], o_cnt[i], o_le[i], o_fe[i]} != '0) begin
          n_errors++;
          $display("FAIL reset_outputs inst=%0d: outputs nonzero during reset (clken=%b data=%h cnt=%0d), required all 0",
                   i, o_clken[i], o_data[i], o_cnt[i]);
        end
      end else begin
        if (o_clken[i]) begin
          pop_ev(i, e, ok);
          n_checks++;
          if (!ok || e.kind != 0) begin
            n_errors++;
            $display("FAIL pixel_unexpected inst=%0d: clken with data=%h x=%0d y=%0d, required kind=%0d (queued=%0d)",
                     i, o_data[i], o_x[i], o_y[i], e.kind, ok);
          end else if (o_data[i] != e.d || int'(o_x[i]) != e.x || int'(o_y[i]) != e.y ||
                       !o_vs[i] || !o_href[i]) begin
            n_errors++;
            $display("FAIL pixel inst=%0d: got data=%h x=%0d y=%0d vs=%b href=%b, required data=%h x=%0d y=%0d vs=1 href=1",
                     i, o_data[i], o_x[i], o_y[i], o_vs[i], o_href[i], e.d, e.x, e.y);
          end
          if (ok && e.kind == 0 && e.lat) begin
            n_checks++;
            if (cyc != lat_expect) begin
              n_errors++;
              $display("FAIL pixel_latency: clken at cycle %0d, required cycle %0d", cyc, lat_expect);
            end
          end
        end
        if (o_le[i]) begin
          pop_ev(i, e, ok);
          n_checks++;
          if (!ok || e.kind != 1) begin
            n_errors++;
            $display("FAIL line_err inst=%0d: line_err pulse, required event kind=%0d (queued=%0d)", i, e.kind, ok);
          end
        end
        if (o_fd[i]) begin
          pop_ev(i, e, ok);
          n_checks++;
          if (!ok || e.kind != 2) begin
            n_errors++;
            $display("FAIL frame_done inst=%0d: frame_done pulse, required event kind=%0d (queued=%0d)", i, e.kind, ok);
          end else if (o_fe[i] != e.ferr || o_cnt[i] != e.cnt) begin
            n_errors++;
            $display("FAIL frame_status inst=%0d: got frame_err=%b frame_cnt=%0d, required frame_err=%b frame_cnt=%0d",
                     i, o_fe[i], o_cnt[i], e.ferr, e.cnt);
          end
        end else if (o_fe[i]) begin
          n_checks++;
          n_errors++;
          $display("FAIL frame_err_alone inst=%0d: frame_err=1 without frame_done, required 0", i);
        end
      end
    end
  end

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) fcnt[i] = 0;
    rst_n = 1'b0;
    repeat (12) drive(1'($urandom), 1'($urandom), 8'($urandom));
    // frame already running when reset releases: never output, its end still counts
    repeat (2) drive(1'b1, 1'b0, 8'($urandom));
    repeat (4) drive(1'b1, 1'b1, 8'($urandom));
    rst_n = 1'b1;
    repeat (3) drive(1'b1, 1'b1, 8'($urandom));
    repeat (3) drive(1'b1, 1'b0, 8'($urandom));
    repeat (8) drive(1'b1, 1'b1, 8'($urandom));
    repeat (2) drive(1'b1, 1'b0, 8'($urandom));
    drive(1'b0, 1'b0, 8'($urandom));
    falls++;

    add_line(8, 0, 0); add_line(8, 0, 0);
    run_frame(1'b0, 1'b0);
    add_line(8, 1, 0); add_line(8, 0, 0);
    run_frame(1'b0, 1'b1);
    add_line(7, 0, 0); add_line(8, 0, 0);
    run_frame(1'b0, 1'b0);
    add_line(8, 0, 0); add_line(8, 0, 0); add_line(8, 0, 0);
    run_frame(1'b0, 1'b0);
    add_line(8, 0, 0); add_line(6, 0, 0);
    run_frame(1'b1, 1'b0);
    for (int l = 0; l < 4; l++) add_line(8, 2, l * 8);
    run_frame(1'b0, 1'b0);
    add_line(1, 0, 0); add_line(8, 0, 0); add_line(8, 0, 0);
    run_frame(1'b0, 1'b0);
    for (int f = 0; f < 8; f++) begin
      int nl;
      nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++)
        add_line(($urandom_range(0, 2) == 0) ? $urandom_range(5, 9) : 8, 0, 0);
      run_frame(1'($urandom_range(0, 3) == 0), 1'b0);
    end
    repeat (10) drive(1'b0, 1'b0, 8'd0);

    n_checks++;
    if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      n_errors++;
      $display("FAIL queues_drained: pending events %0d/%0d/%0d, required 0/0/0", q0.size(), q1.size(), q2.size());
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (int'(o_cnt[i]) != fcnt[i]) begin
        n_errors++;
        $display("FAIL final_frame_cnt inst=%0d: got %0d, required %0d", i, o_cnt[i], fcnt[i]);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
